seg7_scan_ctrl: RTL

//  Avalon-MM slave holding one hex nibble per digit for a multi-digit common-anode/cathode 7-seg display.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_hex_decode.sv | 19 +
 rtl/seg7_scan_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan controller:
//   - register word addresses of the Avalon-MM slave
//   - hex2seg(): nibble -> active-high segment pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [2:0] ADDR_DIGITS = 3'd0;
    localparam logic [2:0] ADDR_BLANK  = 3'd1;
    localparam logic [2:0] ADDR_BLINK  = 3'd2;
    localparam logic [2:0] ADDR_DP     = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;

    // Hex glyphs, lower-case b and d so they differ from 8 and 0.
    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = 7'h3F;
            4'h1:    pattern = 7'h06;
            4'h2:    pattern = 7'h5B;
            4'h3:    pattern = 7'h4F;
            4'h4:    pattern = 7'h66;
            4'h5:    pattern = 7'h6D;
            4'h6:    pattern = 7'h7D;
            4'h7:    pattern = 7'h07;
            4'h8:    pattern = 7'h7F;
            4'h9:    pattern = 7'h6F;
            4'hA:    pattern = 7'h77;
            4'hB:    pattern = 7'h7C;
            4'hC:    pattern = 7'h39;
            4'hD:    pattern = 7'h5E;
            4'hE:    pattern = 7'h79;
            4'hF:    pattern = 7'h71;
            default: pattern = 7'h00;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational nibble to 7-segment decoder (active-high pattern).
// Ports:
//   nibble_i  in  4  hex value
//   seg_o     out 7  segments {g,f,e,d,c,b,a}, 1 = segment on
// -----------------------------------------------------------------------------
module seg7_hex_decode (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    import seg7_pkg::*;

    // Table lookup through the shared decode function.
    always_comb begin
        seg_o = hex2seg(nibble_i);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Avalon-MM slave holding one hex nibble per digit; decodes the selected
// nibble and time-multiplexes the digits onto shared segment pins, with
// per-digit blanking, blinking and decimal point.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   address/chipselect/
//   write_n/writedata       register write port (5 words, see seg7_pkg)
//   readdata                combinational read data, zero wait states
//   seg_out, dp_out         segment / decimal point pins, polarity per ACTIVE_LOW_SEG
//   digit_en                one-hot active-high digit select
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 64,
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] digit_en
);
    import seg7_pkg::*;

    localparam int PW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_UNLIT = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
    localparam logic       DP_UNLIT  = ACTIVE_LOW_SEG ? 1'b1  : 1'b0;

    // Register file
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [NUM_DIGITS-1:0]   blink_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic                    enable_q;

    // Scan state
    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;

    // Output registers
    logic [6:0]            seg_q,      seg_d;
    logic                  dp_q_out,   dp_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;

    logic       wr_en_s;
    logic [3:0] nibble_s;
    logic [6:0] pattern_s;
    logic       dark_s;
    logic       unused_s;

    assign wr_en_s  = chipselect & ~write_n;
    // writedata bits above the implemented fields are intentionally dropped.
    assign unused_s = &{1'b0, writedata};

    // Register writes; unmapped addresses leave all registers untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits_q <= '0;
            blank_q  <= '0;
            blink_q  <= '0;
            dp_q     <= '0;
            enable_q <= 1'b0;
        end else if (wr_en_s) begin
            case (address)
                ADDR_DIGITS: digits_q <= writedata[4*NUM_DIGITS-1:0];
                ADDR_BLANK:  blank_q  <= writedata[NUM_DIGITS-1:0];
                ADDR_BLINK:  blink_q  <= writedata[NUM_DIGITS-1:0];
                ADDR_DP:     dp_q     <= writedata[NUM_DIGITS-1:0];
                ADDR_CTRL:   enable_q <= writedata[0];
                default:     enable_q <= enable_q;
            endcase
        end
    end

    // Read mux; unimplemented bits and unmapped words read as zero.
    always_comb begin
        readdata = 32'h0000_0000;
        case (address)
            ADDR_DIGITS: readdata[4*NUM_DIGITS-1:0] = digits_q;
            ADDR_BLANK:  readdata[NUM_DIGITS-1:0]   = blank_q;
            ADDR_BLINK:  readdata[NUM_DIGITS-1:0]   = blink_q;
            ADDR_DP:     readdata[NUM_DIGITS-1:0]   = dp_q;
            ADDR_CTRL:   readdata[0]                = enable_q;
            default:     readdata                   = 32'h0000_0000;
        endcase
    end

    // Scan chain next state: prescaler -> digit index -> frame -> blink phase.
    // Disabled forces everything to zero so enabling restarts on digit 0.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        phase_d = phase_q;
        if (!enable_q) begin
            presc_d = '0;
            idx_d   = '0;
            frame_d = '0;
            phase_d = 1'b0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                if (frame_q == FRAME_LAST) begin
                    frame_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + FW'(1);
                end
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    assign nibble_s = digits_q[{idx_q, 2'b00} +: 4];
    assign dark_s   = blank_q[idx_q] | (blink_q[idx_q] & phase_q);

    seg7_hex_decode u_hex_decode (
        .nibble_i (nibble_s),
        .seg_o    (pattern_s)
    );

    // Output next state: lit digit drives its pattern, otherwise all unlit.
    always_comb begin
        if (enable_q && !dark_s) begin
            digit_en_d = NUM_DIGITS'(1) << idx_q;
            seg_d      = ACTIVE_LOW_SEG ? ~pattern_s : pattern_s;
            dp_d       = ACTIVE_LOW_SEG ? ~dp_q[idx_q] : dp_q[idx_q];
        end else begin
            digit_en_d = '0;
            seg_d      = SEG_UNLIT;
            dp_d       = DP_UNLIT;
        end
    end

    // Output registers: segment and digit pins change together, glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_en_q <= '0;
            seg_q      <= SEG_UNLIT;
            dp_q_out   <= DP_UNLIT;
        end else begin
            digit_en_q <= digit_en_d;
            seg_q      <= seg_d;
            dp_q_out   <= dp_d;
        end
    end

    assign digit_en = digit_en_q;
    assign seg_out  = seg_q;
    assign dp_out   = dp_q_out;

endmodule
